// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the memory arbiter.
// - arb_state_t : arbiter FSM state encodings (IDLE / BUSY / RESP)
// - grant_t     : owner codes, also driven out on grant_id
// - is_dc_grant : true for either Dcache grant (used to maintain the fairness bit)
package mem_arbiter_pkg;

   localparam int ARB_ADDR_W = 32;
   localparam int ARB_LINE_W = 128;

   typedef enum logic [1:0] {
      ARB_IDLE = 2'd0,
      ARB_BUSY = 2'd1,
      ARB_RESP = 2'd2
   } arb_state_t;

   typedef enum logic [1:0] {
      GNT_NONE = 2'd0,
      GNT_IC   = 2'd1,
      GNT_DCR  = 2'd2,
      GNT_DCW  = 2'd3
   } grant_t;

   function automatic logic is_dc_grant(input grant_t g);
      return (g == GNT_DCR) || (g == GNT_DCW);
   endfunction

endpackage

// File: rtl/mem_arbiter_arb_priority.sv
// Combinational winner select for the memory arbiter.
// Ports:
//   ic_req  - Icache refill request
//   dcr_req - Dcache refill request
//   dcw_req - Dcache write-back request
//   last_dc - previous grant went to the Dcache (fairness bit)
//   grant   - winning requester code, GNT_NONE when nobody asks
// Default order is DC write > DC read > IC; an IC request preempts both
// Dcache requests when the previous grant went to the Dcache, so a
// streaming Dcache can never starve the Icache.
module mem_arbiter_arb_priority
   import mem_arbiter_pkg::*;
(
   input  logic   ic_req,
   input  logic   dcr_req,
   input  logic   dcw_req,
   input  logic   last_dc,
   output grant_t grant
);

   always_comb begin
      grant = GNT_NONE;
      if (last_dc && ic_req) begin
         grant = GNT_IC;
      end else if (dcw_req) begin
         grant = GNT_DCW;
      end else if (dcr_req) begin
         grant = GNT_DCR;
      end else if (ic_req) begin
         grant = GNT_IC;
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// Memory port arbiter: serves one cache-line transaction at a time for the
// Icache refill, Dcache refill and Dcache write-back masters.
// Ports:
//   clk, reset                 - clock; synchronous active-low reset
//   ic_read_*                  - Icache refill request/address, ack pulse and line
//   dc_read_*                  - Dcache refill request/address, ack pulse and line
//   dc_write_*                 - Dcache write-back request/address/line, ack pulse
//   mem_enable/rw/addr/data_out- registered request to memory_sync
//   mem_data_in, mem_ack       - read line and one-cycle completion from memory
//   grant_id                   - current owner (0 none, 1 IC, 2 DC read, 3 DC write)
// Handshake: a master holds req and addr (and write data) stable until it
// sees its one-cycle ack; memory holds off until mem_enable is seen and
// answers with a single mem_ack pulse, after which mem_enable drops.
// Every output is a flop; the always_comb block computes next values only.
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int ADDR_W = ARB_ADDR_W,
   parameter int LINE_W = ARB_LINE_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              ic_read_req,
   input  logic [ADDR_W-1:0] ic_read_addr,
   output logic              ic_read_ack,
   output logic [LINE_W-1:0] ic_read_data,
   input  logic              dc_read_req,
   input  logic [ADDR_W-1:0] dc_read_addr,
   output logic              dc_read_ack,
   output logic [LINE_W-1:0] dc_read_data,
   input  logic              dc_write_req,
   input  logic [ADDR_W-1:0] dc_write_addr,
   input  logic [LINE_W-1:0] dc_write_data,
   output logic              dc_write_ack,
   output logic              mem_enable,
   output logic              mem_rw,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [LINE_W-1:0] mem_data_out,
   input  logic [LINE_W-1:0] mem_data_in,
   input  logic              mem_ack,
   output logic [1:0]        grant_id
);

   arb_state_t        state_q, state_d;
   grant_t            grant_q, grant_d;
   grant_t            win;
   logic              last_dc_q, last_dc_d;
   logic              mem_enable_q, mem_enable_d;
   logic              mem_rw_q, mem_rw_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic [LINE_W-1:0] mem_data_out_q, mem_data_out_d;
   logic [LINE_W-1:0] ic_data_q, ic_data_d;
   logic [LINE_W-1:0] dc_data_q, dc_data_d;
   logic              ic_ack_q, ic_ack_d;
   logic              dcr_ack_q, dcr_ack_d;
   logic              dcw_ack_q, dcw_ack_d;

   mem_arbiter_arb_priority u_priority (
      .ic_req  (ic_read_req),
      .dcr_req (dc_read_req),
      .dcw_req (dc_write_req),
      .last_dc (last_dc_q),
      .grant   (win)
   );

   always_comb begin
      state_d        = state_q;
      grant_d        = grant_q;
      last_dc_d      = last_dc_q;
      mem_enable_d   = mem_enable_q;
      mem_rw_d       = mem_rw_q;
      mem_addr_d     = mem_addr_q;
      mem_data_out_d = mem_data_out_q;
      ic_data_d      = ic_data_q;
      dc_data_d      = dc_data_q;
      // Acks are pulses: high only for the RESP cycle that follows mem_ack.
      ic_ack_d       = 1'b0;
      dcr_ack_d      = 1'b0;
      dcw_ack_d      = 1'b0;

      case (state_q)
         ARB_IDLE: begin
            if (win != GNT_NONE) begin
               state_d      = ARB_BUSY;
               grant_d      = win;
               last_dc_d    = is_dc_grant(win);
               mem_enable_d = 1'b1;
               mem_rw_d     = (win == GNT_DCW);
               case (win)
                  GNT_IC:  mem_addr_d = ic_read_addr;
                  GNT_DCR: mem_addr_d = dc_read_addr;
                  GNT_DCW: begin
                     mem_addr_d     = dc_write_addr;
                     mem_data_out_d = dc_write_data;
                  end
                  default: ;
               endcase
            end
         end

         ARB_BUSY: begin
            // grant_q still names the owner here; it is cleared together
            // with the ack so grant_id reads 0 while the ack is visible.
            if (mem_ack) begin
               state_d      = ARB_RESP;
               mem_enable_d = 1'b0;
               grant_d      = GNT_NONE;
               case (grant_q)
                  GNT_IC: begin
                     ic_data_d = mem_data_in;
                     ic_ack_d  = 1'b1;
                  end
                  GNT_DCR: begin
                     dc_data_d = mem_data_in;
                     dcr_ack_d = 1'b1;
                  end
                  GNT_DCW: dcw_ack_d = 1'b1;
                  default: ;
               endcase
            end
         end

         ARB_RESP: begin
            // Gives the master one cycle to drop its request before the
            // next arbitration, so a finished request is never re-granted.
            state_d = ARB_IDLE;
         end

         default: state_d = ARB_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q        <= ARB_IDLE;
         grant_q        <= GNT_NONE;
         last_dc_q      <= 1'b0;
         mem_enable_q   <= 1'b0;
         mem_rw_q       <= 1'b0;
         mem_addr_q     <= '0;
         mem_data_out_q <= '0;
         ic_data_q      <= '0;
         dc_data_q      <= '0;
         ic_ack_q       <= 1'b0;
         dcr_ack_q      <= 1'b0;
         dcw_ack_q      <= 1'b0;
      end else begin
         state_q        <= state_d;
         grant_q        <= grant_d;
         last_dc_q      <= last_dc_d;
         mem_enable_q   <= mem_enable_d;
         mem_rw_q       <= mem_rw_d;
         mem_addr_q     <= mem_addr_d;
         mem_data_out_q <= mem_data_out_d;
         ic_data_q      <= ic_data_d;
         dc_data_q      <= dc_data_d;
         ic_ack_q       <= ic_ack_d;
         dcr_ack_q      <= dcr_ack_d;
         dcw_ack_q      <= dcw_ack_d;
      end
   end

   assign ic_read_ack  = ic_ack_q;
   assign ic_read_data = ic_data_q;
   assign dc_read_ack  = dcr_ack_q;
   assign dc_read_data = dc_data_q;
   assign dc_write_ack = dcw_ack_q;
   assign mem_enable   = mem_enable_q;
   assign mem_rw       = mem_rw_q;
   assign mem_addr     = mem_addr_q;
   assign mem_data_out = mem_data_out_q;
   assign grant_id     = grant_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: priority table, memory model, grant/ack scoreboard.
`timescale 1ns/1ps
module tb_mem_arbiter;
   import mem_arbiter_pkg::*;

   localparam int AW = 32;
   localparam int LW = 128;
   localparam int RW = 2 + AW + LW;   // scoreboard record {grant, addr, data}

   // ---------------- clock / reset / DUT ----------------
   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic          ic_read_req = 1'b0, dc_read_req = 1'b0, dc_write_req = 1'b0;
   logic [AW-1:0] ic_read_addr = '0, dc_read_addr = '0, dc_write_addr = '0;
   logic [LW-1:0] dc_write_data = '0, mem_data_in = '0;
   logic          mem_ack = 1'b0;
   logic          ic_read_ack, dc_read_ack, dc_write_ack;
   logic [LW-1:0] ic_read_data, dc_read_data, mem_data_out;
   logic          mem_enable, mem_rw;
   logic [AW-1:0] mem_addr;
   logic [1:0]    grant_id;

   always #5 clk = ~clk;

   mem_arbiter dut (
      .clk(clk), .reset(reset),
      .ic_read_req(ic_read_req), .ic_read_addr(ic_read_addr),
      .ic_read_ack(ic_read_ack), .ic_read_data(ic_read_data),
      .dc_read_req(dc_read_req), .dc_read_addr(dc_read_addr),
      .dc_read_ack(dc_read_ack), .dc_read_data(dc_read_data),
      .dc_write_req(dc_write_req), .dc_write_addr(dc_write_addr),
      .dc_write_data(dc_write_data), .dc_write_ack(dc_write_ack),
      .mem_enable(mem_enable), .mem_rw(mem_rw), .mem_addr(mem_addr),
      .mem_data_out(mem_data_out), .mem_data_in(mem_data_in),
      .mem_ack(mem_ack), .grant_id(grant_id)
   );

   // Standalone priority instance for the exhaustive table.
   logic   t_ic = 1'b0, t_dcr = 1'b0, t_dcw = 1'b0, t_last = 1'b0;
   grant_t t_gnt;
   mem_arbiter_arb_priority u_prio (
      .ic_req(t_ic), .dcr_req(t_dcr), .dcw_req(t_dcw), .last_dc(t_last), .grant(t_gnt)
   );

   // ---------------- checking helpers ----------------
   int checks = 0;
   int failures = 0;

   task automatic check(input string name, input logic [RW-1:0] act, input logic [RW-1:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s: actual=%0h required=%0h", name, act, req);
      end
   endtask

   function automatic logic [LW-1:0] rdata_for(input logic [AW-1:0] a);
      if (a == 32'h0000_0040) return {16{8'hA5}};
      return {~a, a, a ^ 32'h5A5A_0F0F, a + 32'h1234_5678};
   endfunction

   function automatic logic [LW-1:0] wdata_for(input logic [AW-1:0] a);
      return {32'hDEAD_BEEF, a, ~a, 32'hCAFE_F00D};
   endfunction

   function automatic logic [RW-1:0] mk(input logic [1:0] g, input logic [AW-1:0] a);
      return {g, a, (g == 2'd3) ? wdata_for(a) : rdata_for(a)};
   endfunction

   // ---------------- memory model ----------------
   int mem_lat = 3;
   int mem_cnt = 0;
   int spur_req = 0;
   int spur_done = 0;

   always @(negedge clk) begin
      if (!reset) begin
         mem_ack = 1'b0;
         mem_cnt = 0;
      end else if (mem_ack) begin
         mem_ack = 1'b0;
      end else if (spur_req != spur_done) begin
         spur_done = spur_req;
         mem_ack = 1'b1;
         mem_data_in = {4{32'hBAD0_BAD0}};
      end else if (mem_enable) begin
         mem_cnt++;
         if (mem_cnt == mem_lat) begin
            mem_ack = 1'b1;
            mem_data_in = rdata_for(mem_addr);
            mem_cnt = 0;
         end
      end else begin
         mem_cnt = 0;
      end
   end

   // ---------------- scoreboard / monitor ----------------
   logic [RW-1:0] exp_q[$];
   logic [RW-1:0] cur;
   logic [1:0]    cg;
   logic [AW-1:0] ca;
   logic [LW-1:0] cd;
   bit            cur_valid = 1'b0;
   bit            prev_en = 1'b0;
   logic [LW-1:0] exp_ic_data = '0, exp_dc_data = '0;
   int            ack_cnt[4] = '{0, 0, 0, 0};

   always @(negedge clk) begin
      if (!reset) begin
         cur_valid = 1'b0;
         prev_en = 1'b0;
         exp_ic_data = '0;
         exp_dc_data = '0;
      end else begin
         if (mem_enable && !prev_en) begin
            if (exp_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_grant: grant_id=%0d addr=%0h, required no grant", grant_id, mem_addr);
            end else begin
               cur = exp_q.pop_front();
               cg = cur[RW-1:RW-2];
               ca = cur[RW-3:LW];
               cd = cur[LW-1:0];
               cur_valid = 1'b1;
               check("grant_id", RW'(grant_id), RW'(cg));
               check("grant_rw", RW'(mem_rw), RW'(cg == 2'd3));
               check("grant_addr", RW'(mem_addr), RW'(ca));
               if (cg == 2'd3) check("grant_wdata", RW'(mem_data_out), RW'(cd));
            end
         end else if (mem_enable && cur_valid) begin
            if (cg == 2'd3) check("hold_write", RW'({mem_rw, mem_addr, mem_data_out}), RW'({1'b1, ca, cd}));
            else            check("hold_read", RW'({mem_rw, mem_addr}), RW'({1'b0, ca}));
         end

         if (ic_read_ack || dc_read_ack || dc_write_ack) begin
            if (!cur_valid) begin
               checks++;
               failures++;
               $display("FAIL unexpected_ack: acks=%b, required 000", {ic_read_ack, dc_read_ack, dc_write_ack});
            end else begin
               check("ack_onehot", RW'({ic_read_ack, dc_read_ack, dc_write_ack}),
                     RW'((cg == 2'd1) ? 3'b100 : (cg == 2'd2) ? 3'b010 : 3'b001));
               check("ack_idle_outputs", RW'({mem_enable, grant_id}), RW'(3'b000));
               if (cg == 2'd1) exp_ic_data = cd;
               if (cg == 2'd2) exp_dc_data = cd;
               check("ic_read_data", RW'(ic_read_data), RW'(exp_ic_data));
               check("dc_read_data", RW'(dc_read_data), RW'(exp_dc_data));
               ack_cnt[cg]++;
               cur_valid = 1'b0;
            end
         end
         prev_en = mem_enable;
      end
   end

   // ---------------- driver tasks ----------------
   int            remaining[4];
   int            issued[4];
   logic [AW-1:0] base[4];

   task automatic set_req(input int m, input logic v);
      case (m)
         1:       ic_read_req = v;
         2:       dc_read_req = v;
         default: dc_write_req = v;
      endcase
   endtask

   task automatic raise(input int m);
      logic [AW-1:0] a;
      a = base[m] + AW'(issued[m] * 16);
      case (m)
         1: ic_read_addr = a;
         2: dc_read_addr = a;
         default: begin
            dc_write_addr = a;
            dc_write_data = wdata_for(a);
         end
      endcase
      set_req(m, 1'b1);
   endtask

   task automatic setup(input int n_ic, input int n_dcr, input int n_dcw,
                        input logic [AW-1:0] b_ic, input logic [AW-1:0] b_dcr, input logic [AW-1:0] b_dcw);
      remaining[1] = n_ic;  remaining[2] = n_dcr;  remaining[3] = n_dcw;
      issued = '{0, 0, 0, 0};
      base[1] = b_ic;  base[2] = b_dcr;  base[3] = b_dcw;
   endtask

   // Requesters: raise when work remains, drop on seeing ack, stay low one
   // cycle before re-raising. Returns when all work is acked or on timeout.
   task automatic run_engine(input int budget);
      bit   dropped[4];
      logic ackm, reqm;
      int   cyc;
      dropped = '{0, 0, 0, 0};
      cyc = 0;
      while (remaining[1] + remaining[2] + remaining[3] > 0) begin
         @(negedge clk);
         cyc++;
         if (cyc > budget) begin
            checks++;
            failures++;
            $display("FAIL engine_timeout: outstanding=%0d after %0d cycles, required 0",
                     remaining[1] + remaining[2] + remaining[3], budget);
            remaining = '{0, 0, 0, 0};
            ic_read_req = 1'b0; dc_read_req = 1'b0; dc_write_req = 1'b0;
            break;
         end
         for (int m = 1; m <= 3; m++) begin
            ackm = (m == 1) ? ic_read_ack : (m == 2) ? dc_read_ack : dc_write_ack;
            reqm = (m == 1) ? ic_read_req : (m == 2) ? dc_read_req : dc_write_req;
            if (reqm && ackm) begin
               set_req(m, 1'b0);
               remaining[m]--;
               issued[m]++;
               dropped[m] = 1'b1;
            end else if (!reqm && remaining[m] > 0 && !dropped[m]) begin
               raise(m);
            end else begin
               dropped[m] = 1'b0;
            end
         end
      end
      repeat (3) @(negedge clk);
   endtask

   task automatic do_reset();
      reset = 1'b0;
      ic_read_req = 1'b0; dc_read_req = 1'b0; dc_write_req = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
   endtask

   // ---------------- priority vector table ----------------
   typedef struct packed {
      logic       ic;
      logic       dcr;
      logic       dcw;
      logic       last_dc;
      logic [1:0] exp;
   } prio_vec_t;

   prio_vec_t vecs[16];

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   // ---------------- test sequence ----------------
   initial begin
      int snap[4];
      int seen;
      bit saw_en;

      //            ic    dcr   dcw   last  exp
      vecs[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, 2'd0};
      vecs[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 2'd1};
      vecs[2]  = '{1'b0, 1'b1, 1'b0, 1'b0, 2'd2};
      vecs[3]  = '{1'b1, 1'b1, 1'b0, 1'b0, 2'd2};
      vecs[4]  = '{1'b0, 1'b0, 1'b1, 1'b0, 2'd3};
      vecs[5]  = '{1'b1, 1'b0, 1'b1, 1'b0, 2'd3};
      vecs[6]  = '{1'b0, 1'b1, 1'b1, 1'b0, 2'd3};
      vecs[7]  = '{1'b1, 1'b1, 1'b1, 1'b0, 2'd3};
      vecs[8]  = '{1'b0, 1'b0, 1'b0, 1'b1, 2'd0};
      vecs[9]  = '{1'b1, 1'b0, 1'b0, 1'b1, 2'd1};
      vecs[10] = '{1'b0, 1'b1, 1'b0, 1'b1, 2'd2};
      vecs[11] = '{1'b1, 1'b1, 1'b0, 1'b1, 2'd1};
      vecs[12] = '{1'b0, 1'b0, 1'b1, 1'b1, 2'd3};
      vecs[13] = '{1'b1, 1'b0, 1'b1, 1'b1, 2'd1};
      vecs[14] = '{1'b0, 1'b1, 1'b1, 1'b1, 2'd3};
      vecs[15] = '{1'b1, 1'b1, 1'b1, 1'b1, 2'd1};

      for (int i = 0; i < 16; i++) begin
         t_ic = vecs[i].ic; t_dcr = vecs[i].dcr; t_dcw = vecs[i].dcw; t_last = vecs[i].last_dc;
         #1;
         check($sformatf("prio_vec%0d", i), RW'(t_gnt), RW'(vecs[i].exp));
      end

      // Reset values.
      repeat (3) @(negedge clk);
      check("rst_ctrl", RW'({mem_enable, mem_rw, grant_id}), RW'(4'b0000));
      check("rst_acks", RW'({ic_read_ack, dc_read_ack, dc_write_ack}), RW'(3'b000));
      check("rst_mem_addr", RW'(mem_addr), RW'(0));
      check("rst_mem_data_out", RW'(mem_data_out), RW'(0));
      check("rst_read_data", RW'({ic_read_data, dc_read_data}), RW'(0));
      reset = 1'b1;
      @(negedge clk);

      // Single IC read at 0x40, 3-cycle memory: cycle-exact enable/ack shape.
      exp_q.push_back(mk(2'd1, 32'h40));
      ic_read_addr = 32'h40;
      ic_read_req = 1'b1;
      for (int k = 1; k <= 5; k++) begin
         @(negedge clk);
         check($sformatf("ic_single_en_k%0d", k), RW'({mem_enable, mem_rw}), RW'({k <= 3, 1'b0}));
         check($sformatf("ic_single_gid_k%0d", k), RW'(grant_id), RW'((k <= 3) ? 2'd1 : 2'd0));
         check($sformatf("ic_single_ack_k%0d", k), RW'(ic_read_ack), RW'(k == 4));
         if (ic_read_ack) ic_read_req = 1'b0;
      end
      ic_read_req = 1'b0;
      check("ic_single_data", RW'(ic_read_data), RW'({16{8'hA5}}));

      // DC write-back to 0x100; dc_read_data must stay untouched.
      snap = ack_cnt;
      setup(0, 0, 1, '0, '0, 32'h100);
      exp_q.push_back(mk(2'd3, 32'h100));
      run_engine(100);
      check("dcw_ack_count", RW'(ack_cnt[3] - snap[3]), RW'(1));
      check("dcw_dc_read_data_kept", RW'(dc_read_data), RW'(0));

      // All three at once with last_dc=0: DCW, IC, DCR.
      do_reset();
      snap = ack_cnt;
      setup(1, 1, 1, 32'h600, 32'h700, 32'h500);
      exp_q.push_back(mk(2'd3, 32'h500));
      exp_q.push_back(mk(2'd1, 32'h600));
      exp_q.push_back(mk(2'd2, 32'h700));
      run_engine(200);
      check("all3_ack_ic", RW'(ack_cnt[1] - snap[1]), RW'(1));
      check("all3_ack_dcr", RW'(ack_cnt[2] - snap[2]), RW'(1));
      check("all3_ack_dcw", RW'(ack_cnt[3] - snap[3]), RW'(1));

      // Streaming DC reads with IC held: DCR, IC, DCR, IC, ...
      do_reset();
      snap = ack_cnt;
      setup(3, 3, 0, 32'h800, 32'h900, '0);
      for (int k = 0; k < 3; k++) begin
         exp_q.push_back(mk(2'd2, 32'h900 + AW'(k * 16)));
         exp_q.push_back(mk(2'd1, 32'h800 + AW'(k * 16)));
      end
      run_engine(300);
      check("stream_ack_ic", RW'(ack_cnt[1] - snap[1]), RW'(3));
      check("stream_ack_dcr", RW'(ack_cnt[2] - snap[2]), RW'(3));

      // Reset in the middle of a long BUSY period.
      mem_lat = 10;
      exp_q.push_back(mk(2'd1, 32'hA00));
      ic_read_addr = 32'hA00;
      ic_read_req = 1'b1;
      saw_en = 1'b0;
      for (int k = 0; k < 10 && !saw_en; k++) begin
         @(negedge clk);
         saw_en = mem_enable;
      end
      check("midbusy_grant_seen", RW'(saw_en), RW'(1));
      repeat (2) @(negedge clk);
      reset = 1'b0;
      ic_read_req = 1'b0;
      @(negedge clk);
      check("midbusy_rst_ctrl", RW'({mem_enable, grant_id}), RW'(3'b000));
      check("midbusy_rst_acks", RW'({ic_read_ack, dc_read_ack, dc_write_ack}), RW'(3'b000));
      reset = 1'b1;
      mem_lat = 3;
      seen = 0;
      repeat (6) begin
         @(negedge clk);
         seen += int'(ic_read_ack) + int'(dc_read_ack) + int'(dc_write_ack) + int'(mem_enable);
      end
      check("midbusy_quiet_after", RW'(seen), RW'(0));
      setup(1, 0, 0, 32'hB00, '0, '0);
      exp_q.push_back(mk(2'd1, 32'hB00));
      run_engine(100);
      check("midbusy_fresh_ic", RW'(ic_read_data), RW'(rdata_for(32'hB00)));

      // Spurious mem_ack while IDLE.
      spur_req++;
      seen = 0;
      repeat (4) begin
         @(negedge clk);
         seen += int'(ic_read_ack) + int'(dc_read_ack) + int'(dc_write_ack) + int'(mem_enable);
      end
      check("spurious_quiet", RW'(seen), RW'(0));
      check("spurious_gid", RW'(grant_id), RW'(0));
      check("spurious_data_kept", RW'(ic_read_data), RW'(rdata_for(32'hB00)));
      setup(0, 1, 0, '0, 32'hC00, '0);
      exp_q.push_back(mk(2'd2, 32'hC00));
      run_engine(100);
      check("spurious_then_dcr", RW'(dc_read_data), RW'(rdata_for(32'hC00)));

      check("exp_q_drained", RW'(exp_q.size()), RW'(0));
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Arbitrates the single external memory port between three cache-side masters: Icache line refill (read), Dcache line refill (read) and Dcache write-back (write).
- Sits directly downstream of the Icache/Dcache miss interfaces in the cpu top and directly upstream of memory_sync.
- Serves one line transaction at a time, with registered request/ack handshakes on both sides.

Parameters:
ADDR_W, 32, byte address width (matches REG_SIZE)
LINE_W, 128, cache line / memory data width (matches WIDTH)

Ports:
clk  input  1  clock, all logic on posedge
reset  input  1  synchronous, active-low reset (0 = reset)
ic_read_req  input  1  Icache refill request, held until ic_read_ack
ic_read_addr  input  ADDR_W  Icache refill line address
ic_read_ack  output  1  one-cycle completion pulse to Icache
ic_read_data  output  LINE_W  refill line for Icache
dc_read_req  input  1  Dcache refill request
dc_read_addr  input  ADDR_W  Dcache refill address
dc_read_ack  output  1  one-cycle completion pulse
dc_read_data  output  LINE_W  refill line for Dcache
dc_write_req  input  1  Dcache write-back request
dc_write_addr  input  ADDR_W  write-back address
dc_write_data  input  LINE_W  write-back line
dc_write_ack  output  1  one-cycle completion pulse
mem_enable  output  1  memory transaction active
mem_rw  output  1  1 = write, 0 = read
mem_addr  output  ADDR_W  memory address
mem_data_out  output  LINE_W  write data to memory
mem_data_in  input  LINE_W  read data from memory
mem_ack  input  1  one-cycle completion pulse from memory
grant_id  output  2  current owner: 0 none, 1 IC, 2 DC read, 3 DC write (debug/perf)

Behaviour:
- All outputs are registered.
- Reset (reset==0 at posedge): state IDLE; mem_enable, mem_rw, all acks and grant_id = 0; mem_addr, mem_data_out, ic_read_data, dc_read_data = 0; last_dc = 0.
- FSM states:
  - IDLE: sample requests, pick a winner, load mem_addr/mem_rw/mem_data_out, set mem_enable=1 and grant_id, go to BUSY.
  - BUSY: hold mem_enable/mem_rw/mem_addr/mem_data_out stable. On mem_ack: drop mem_enable, capture mem_data_in into the winner's read_data register (reads only), pulse the winner's ack, clear grant_id, go to RESP.
  - RESP: one cycle with ack high. Acks clear on exit. No new grant is issued in RESP. Go to IDLE.
- Arbitration, evaluated in IDLE only:
  - DC write > DC read > IC by default.
  - Fairness: if last_dc==1 and ic_read_req==1, IC wins.
  - last_dc set on any DC grant, cleared on an IC grant.
- Latency: request visible at posedge T → mem_enable high from T+1. mem_ack sampled at posedge N → ack and data valid in cycle N+1. Earliest next grant at N+2. Back-to-back throughput is one transaction per (memory latency + 2) cycles.
- Requesters keep req and addr stable until they see ack, then drop req the following cycle. Sampling in IDLE after RESP therefore never sees a stale req.
- Read data registers hold their value until the next read completion for the same master.
- Boundary conditions:
  - Simultaneous requests from all three: DCW, then IC (fairness), then DCR.
  - A requester deasserting req mid-BUSY is illegal. The transaction still completes and the ack still pulses.
  - mem_ack while in IDLE or RESP is ignored.
  - mem_ack in the same cycle as the grant cannot occur, because mem_enable is registered.
  - Reset mid-BUSY: transaction abandoned and mem_enable drops next cycle; memory_sync must tolerate this.
  - Address is passed unmodified; line alignment is the caches' responsibility.

Decomposition:
- define.v (shared): state encodings ARB_IDLE/ARB_BUSY/ARB_RESP and grant codes GNT_NONE/GNT_IC/GNT_DCR/GNT_DCW.
- One natural sub-module, arb_priority: combinational winner select from (ic_req, dcr_req, dcw_req, last_dc) → grant code. Kept separate so it can be tested exhaustively.

Test Plan:
- Single IC read at 0x0000_0040, memory returns 0xA5…A5 after 3 cycles: mem_enable high T+1..T+3 with mem_rw=0; ic_read_ack pulses once at T+4 with ic_read_data = 0xA5…A5; grant_id returns to 0.
- DC write-back to 0x100 with data 0xDEADBEEF_…: mem_rw=1, mem_data_out stable for the whole BUSY period, dc_write_ack pulses once, dc_read_data unchanged.
- All three requests at the same cycle with last_dc=0: grant order DCW, IC, DCR; exactly one ack per master and no overlapping mem_enable.
- Continuous dc_read_req streaming with ic_read_req held: grants alternate DCR, IC, DCR, IC; no IC starvation.
- Reset asserted mid-BUSY: next cycle mem_enable=0, grant_id=0, no ack pulses; after release a fresh IC request completes normally.
- Spurious mem_ack while IDLE: no ack outputs and no state change.
